// File: rtl/clk_ctrl.sv
// Clock-enable controller for the pipelined core: issues one-cycle CPU_CE pulses
// at a programmable ratio and sequences halted / running / single-step operation.
module clk_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             CLKIN,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIV,
    input  logic             RUN_REQ,
    input  logic             STEP_REQ,
    input  logic             HALT_REQ,
    input  logic             BRK_HIT,
    input  logic             CNT_CLR,
    output logic             CPU_CE,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] CE_CNT,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_HALTED   = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_STEPPING = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
    logic             busy_q;
    logic             run_prev_q, step_prev_q, halt_prev_q;

    logic run_edge, step_edge, halt_edge, terminal;

    assign run_edge  = RUN_REQ  & ~run_prev_q;
    assign step_edge = STEP_REQ & ~step_prev_q;
    assign halt_edge = HALT_REQ & ~halt_prev_q;
    assign terminal  = (div_cnt_q == div_l_q);

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_l_d   = div_l_q;
        ce_d      = 1'b0;

        unique case (state_q)
            ST_HALTED: begin
                div_cnt_d = '0;
                // A coincident HALT edge outranks STEP/RUN; BRK_HIT is ignored so
                // the core can be run or stepped off a breakpoint.
                if (!halt_edge && step_edge) begin
                    state_d = ST_STEPPING;
                    div_l_d = DIV;
                end else if (!halt_edge && run_edge) begin
                    state_d = ST_RUNNING;
                    div_l_d = DIV;
                end
            end

            ST_RUNNING: begin
                if (halt_edge || BRK_HIT) begin
                    state_d   = ST_HALTED;
                    div_cnt_d = '0;
                end else if (terminal) begin
                    div_cnt_d = '0;
                    ce_d      = 1'b1;
                    div_l_d   = DIV;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_STEPPING: begin
                if (halt_edge) begin
                    state_d   = ST_HALTED;
                    div_cnt_d = '0;
                end else if (terminal) begin
                    state_d   = ST_HALTED;
                    div_cnt_d = '0;
                    ce_d      = 1'b1;
                    div_l_d   = DIV;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = ST_HALTED;
                div_cnt_d = '0;
            end
        endcase

        if (CNT_CLR) begin
            ce_cnt_d = '0;
        end else begin
            ce_cnt_d = ce_cnt_q + {{(CNT_W-1){1'b0}}, ce_d};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLKIN) begin
        if (!RST) begin
            state_q     <= ST_HALTED;
            div_cnt_q   <= '0;
            div_l_q     <= '0;
            ce_q        <= 1'b0;
            ce_cnt_q    <= '0;
            busy_q      <= 1'b0;
            // Loaded high so a request held through reset must be released first.
            run_prev_q  <= 1'b1;
            step_prev_q <= 1'b1;
            halt_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_l_q     <= div_l_d;
            ce_q        <= ce_d;
            ce_cnt_q    <= ce_cnt_d;
            busy_q      <= (state_d != ST_HALTED);
            run_prev_q  <= RUN_REQ;
            step_prev_q <= STEP_REQ;
            halt_prev_q <= HALT_REQ;
        end
    end

    assign CPU_CE = ce_q;
    assign STATE  = state_q;
    assign CE_CNT = ce_cnt_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl: a countdown-style reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_clk_ctrl;

    logic        CLKIN;
    logic        RST;
    logic [7:0]  DIV;
    logic        RUN_REQ, STEP_REQ, HALT_REQ, BRK_HIT, CNT_CLR;
    logic        CPU_CE;
    logic [1:0]  STATE;
    logic [31:0] CE_CNT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    clk_ctrl #(.DIV_W(8), .CNT_W(32)) dut (
        .CLKIN    (CLKIN),
        .RST      (RST),
        .DIV      (DIV),
        .RUN_REQ  (RUN_REQ),
        .STEP_REQ (STEP_REQ),
        .HALT_REQ (HALT_REQ),
        .BRK_HIT  (BRK_HIT),
        .CNT_CLR  (CNT_CLR),
        .CPU_CE   (CPU_CE),
        .STATE    (STATE),
        .CE_CNT   (CE_CNT),
        .BUSY     (BUSY)
    );

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 halted, 1 running, 2 stepping; m_left counts edges
    // remaining until the next enable and is reloaded with DIV+1.
    int          m_mode  = 0;
    int          m_left  = 0;
    logic        m_ce    = 1'b0;
    logic [31:0] m_cnt   = '0;
    logic        m_prun  = 1'b1, m_pstep = 1'b1, m_phalt = 1'b1;
    bit          m_valid = 1'b0;

    always @(posedge CLKIN) begin
        bit r, s, h;
        r = RUN_REQ  && !m_prun;
        s = STEP_REQ && !m_pstep;
        h = HALT_REQ && !m_phalt;
        m_ce = 1'b0;
        if (!RST) begin
            m_mode = 0;
            m_cnt  = '0;
            m_prun = 1'b1; m_pstep = 1'b1; m_phalt = 1'b1;
            m_valid = 1'b1;
        end else begin
            if (m_mode == 0) begin
                if (h) m_mode = 0;
                else if (s) begin m_mode = 2; m_left = int'(DIV) + 1; end
                else if (r) begin m_mode = 1; m_left = int'(DIV) + 1; end
            end else if (m_mode == 1) begin
                if (h || BRK_HIT) m_mode = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_ce = 1'b1; m_left = int'(DIV) + 1; end
                end
            end else begin
                if (h) m_mode = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_ce = 1'b1; m_mode = 0; end
                end
            end
            if (CNT_CLR) m_cnt = '0;
            else if (m_ce) m_cnt = m_cnt + 1;
            m_prun = RUN_REQ; m_pstep = STEP_REQ; m_phalt = HALT_REQ;
        end
        #1;
        if (m_valid) begin
            check("model_ce",    32'(CPU_CE), 32'(m_ce));
            check("model_state", 32'(STATE),  32'(m_mode));
            check("model_busy",  32'(BUSY),   32'(m_mode != 0));
            check("model_cnt",   CE_CNT,      m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLKIN);
    endtask

    initial begin
        int ce_hits;
        RST = 1'b0; DIV = 8'd0;
        RUN_REQ = 1'b1; STEP_REQ = 1'b1; HALT_REQ = 1'b1; BRK_HIT = 1'b0; CNT_CLR = 1'b0;
        step(3);
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_ce",    32'(CPU_CE), 32'd0);
        check("rst_cnt",   CE_CNT, 32'd0);
        check("rst_busy",  32'(BUSY), 32'd0);

        // Requests held through reset must not act.
        RST = 1'b1;
        step(10);
        check("held_state", 32'(STATE), 32'd0);
        RUN_REQ = 1'b0; STEP_REQ = 1'b0; HALT_REQ = 1'b0;
        step(1);

        // DIV=3 run: pulses after k+4, k+8, k+12.
        DIV = 8'd3; RUN_REQ = 1'b1;
        step(1);
        check("run_enter", 32'(STATE), 32'd1);
        check("run_busy",  32'(BUSY), 32'd1);
        RUN_REQ = 1'b0;
        ce_hits = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("div3_ce_k%0d", i), 32'(CPU_CE), 32'((i % 4) == 0));
        end
        check("div3_cnt", CE_CNT, 32'd3);

        // New ratio only after the next terminal count (k+16), then every cycle.
        DIV = 8'd0;
        for (int i = 13; i <= 20; i++) begin
            step(1);
            check($sformatf("div0_ce_k%0d", i), 32'(CPU_CE), 32'(i >= 16));
        end
        check("div0_cnt", CE_CNT, 32'd8);
        HALT_REQ = 1'b1;
        step(1);
        check("halt_state", 32'(STATE), 32'd0);
        check("halt_ce",    32'(CPU_CE), 32'd0);
        HALT_REQ = 1'b0;
        step(1);

        // Single step with DIV=5: one pulse at k+6, back to HALTED on that edge.
        DIV = 8'd5; STEP_REQ = 1'b1;
        step(1);
        check("step_enter", 32'(STATE), 32'd2);
        STEP_REQ = 1'b0;
        step(5);
        check("step_wait_ce", 32'(CPU_CE), 32'd0);
        step(1);
        check("step_ce",    32'(CPU_CE), 32'd1);
        check("step_state", 32'(STATE), 32'd0);
        check("step_cnt",   CE_CNT, 32'd9);
        STEP_REQ = 1'b1;
        step(1);
        STEP_REQ = 1'b0;
        step(6);
        check("step2_cnt", CE_CNT, 32'd10);

        // Breakpoint at the terminal edge suppresses the pulse.
        DIV = 8'd2; RUN_REQ = 1'b1;
        step(1);
        RUN_REQ = 1'b0;
        step(2);
        BRK_HIT = 1'b1;
        step(1);
        check("brk_ce",    32'(CPU_CE), 32'd0);
        check("brk_state", 32'(STATE), 32'd0);
        STEP_REQ = 1'b1;
        step(1);
        STEP_REQ = 1'b0;
        step(3);
        check("brk_step_ce",  32'(CPU_CE), 32'd1);
        check("brk_step_cnt", CE_CNT, 32'd11);
        RUN_REQ = 1'b1;
        step(1);
        check("brk_run_enter", 32'(STATE), 32'd1);
        step(1);
        check("brk_run_halt", 32'(STATE), 32'd0);
        RUN_REQ = 1'b0; BRK_HIT = 1'b0;
        step(1);

        // Coincident RUN/STEP/HALT from HALTED: HALT wins.
        RUN_REQ = 1'b1; STEP_REQ = 1'b1; HALT_REQ = 1'b1;
        step(1);
        check("same_edge_state", 32'(STATE), 32'd0);
        RUN_REQ = 1'b0; STEP_REQ = 1'b0; HALT_REQ = 1'b0;
        step(1);

        // DIV=7 step, repeated STEP ignored, HALT three cycles in.
        DIV = 8'd7; STEP_REQ = 1'b1;
        step(1);
        STEP_REQ = 1'b0;
        step(1);
        STEP_REQ = 1'b1;
        step(1);
        check("step_restep_state", 32'(STATE), 32'd2);
        STEP_REQ = 1'b0; HALT_REQ = 1'b1;
        step(1);
        check("step_halt_state", 32'(STATE), 32'd0);
        check("step_halt_ce",    32'(CPU_CE), 32'd0);
        check("step_halt_cnt",   CE_CNT, 32'd11);
        HALT_REQ = 1'b0;
        step(1);

        // Mid-run reset.
        DIV = 8'd1; RUN_REQ = 1'b1;
        step(1);
        RUN_REQ = 1'b0;
        step(4);
        check("div1_ce",  32'(CPU_CE), 32'd1);
        check("div1_cnt", CE_CNT, 32'd13);
        RST = 1'b0;
        step(1);
        check("midrst_state", 32'(STATE), 32'd0);
        check("midrst_ce",    32'(CPU_CE), 32'd0);
        check("midrst_cnt",   CE_CNT, 32'd0);
        check("midrst_busy",  32'(BUSY), 32'd0);
        RST = 1'b1;
        step(1);

        // CNT_CLR coincident with a pulse: pulse issued, not counted.
        DIV = 8'd0; RUN_REQ = 1'b1;
        step(1);
        RUN_REQ = 1'b0;
        step(3);
        check("clr_pre_cnt", CE_CNT, 32'd3);
        CNT_CLR = 1'b1;
        step(1);
        check("clr_ce",  32'(CPU_CE), 32'd1);
        check("clr_cnt", CE_CNT, 32'd0);
        CNT_CLR = 1'b0;
        step(1);
        check("clr_post_cnt", CE_CNT, 32'd1);
        HALT_REQ = 1'b1;
        step(1);
        check("final_state", 32'(STATE), 32'd0);
        check("final_cnt",   CE_CNT, 32'd1);
        HALT_REQ = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_ctrl.md
# clk_ctrl

Processor clock-enable controller for the pipelined RISC-V core on the DE2-115. It does not divide or gate the clock. It produces a one-cycle CPU_CE pulse on the single CLKIN domain at a programmable rate. It sequences the core through halted, free-running and single-step operation from board requests and a breakpoint input. It also keeps a count of issued enables for the debug display.

## Interface
- DIV_W, 8: width of the division ratio.
- CNT_W, 32: width of the enable counter.

- CLKIN  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-low reset.
- DIV  in  DIV_W  ratio; one CPU_CE every DIV+1 CLKIN cycles while running. DIV=0 gives CE every cycle.
- RUN_REQ  in  1  level; a rising edge requests RUNNING.
- STEP_REQ  in  1  level; a rising edge requests exactly one CE.
- HALT_REQ  in  1  level; a rising edge requests HALTED.
- BRK_HIT  in  1  level; breakpoint match from the core's PC comparator.
- CNT_CLR  in  1  level; clears CE_CNT while high.
- CPU_CE  out  1  registered clock-enable pulse to the core.
- STATE  out  2  00 HALTED, 01 RUNNING, 10 STEPPING. 11 is never driven.
- CE_CNT  out  CNT_W  number of CPU_CE pulses issued; wraps modulo 2^CNT_W.
- BUSY  out  1  high when STATE is not HALTED.

## Operation
- Edge detection: each request has a previous-sample register. A request is active at an edge when the current sample is 1 and the previous sample is 0. Reset loads all previous-sample registers with 1, so a request held through reset is ignored until released and pressed again.
- Divider: an internal counter CNT (DIV_W bits) and a latched ratio DIV_L.
  - CNT is cleared on entry to RUNNING or STEPPING. DIV_L is loaded from DIV at the same edge.
  - In an active state, at each edge: if CNT == DIV_L, then CNT←0, CPU_CE←1, and DIV_L←DIV (a new ratio takes effect only at a terminal count). Otherwise CNT←CNT+1 and CPU_CE←0.
  - In HALTED: CNT←0 and CPU_CE←0.
- States and transitions. At one edge only the highest-priority applicable event acts; priority is HALT > BRK > STEP > RUN.
  - HALTED:
    - STEP edge → STEPPING.
    - RUN edge → RUNNING. If BRK_HIT is high at that edge, RUNNING is still entered (this lets the core run off a breakpoint); the breakpoint is only honoured from the next edge on.
  - RUNNING:
    - HALT edge → HALTED.
    - BRK_HIT high → HALTED.
    - In both cases no CE is issued at that edge, even when CNT == DIV_L.
    - STEP and RUN edges are ignored.
  - STEPPING:
    - At the terminal-count edge, CPU_CE←1 and the state goes to HALTED at that same edge.
    - HALT edge before terminal count → HALTED with no CE issued.
    - BRK_HIT, RUN and STEP are ignored.
- CE_CNT:
  - Increments by 1 at every edge that sets CPU_CE←1.
  - CNT_CLR has priority over the increment: CE_CNT←0 at that edge and the coincident pulse is not counted.
- Reset (RST=0 at an edge):
  - STATE=HALTED, CPU_CE=0, CE_CNT=0, BUSY=0, CNT=0, DIV_L=0.
  - Previous-sample registers are loaded with 1.
  - Reset overrides everything, including a reset asserted mid-step or mid-run.

## Timing
- All outputs are registered. STATE, BUSY and CPU_CE change only on CLKIN rising edges.
- Latency: let edge k be the edge that samples a request rising edge and enters an active state. The first CPU_CE is set at edge k+DIV_L+1 and is high for exactly one cycle.
- While RUNNING with a constant DIV, CE period is DIV+1 cycles, duty 1/(DIV+1). DIV=0 gives CPU_CE continuously high.
- After HALT or BRK at edge h, CPU_CE is 0 from edge h onward. No pulse is ever truncated or stretched.
- BUSY equals (STATE != 00) and is updated at the same edge as STATE.
- CE_CNT updates at the same edge that sets CPU_CE.

## Test plan
- Reset with all requests high, then hold them high for 10 cycles after release → STATE=00, CPU_CE=0, CE_CNT=0 throughout. Release and re-press RUN → RUNNING.
- DIV=3, RUN edge at edge k → CPU_CE high after edges k+4, k+8, k+12, …; CE_CNT=3 after edge k+12. Then DIV=0 → new ratio applies after the next terminal count, after which CPU_CE is high every cycle.
- DIV=5, STEP edge → exactly one CPU_CE, set at edge k+6. STATE returns to 00 at that same edge. CE_CNT increments by 1. A second STEP edge gives one more pulse.
- RUNNING with DIV=2; assert BRK_HIT at the edge where CNT==2 → no CE at that edge, STATE=00. With BRK_HIT still high, a STEP edge produces one CE; a RUN edge enters RUNNING and halts on the next edge.
- Same-edge RUN, STEP and HALT from HALTED → STATE stays 00. Then HALT and STEP edges in STEPPING with DIV=7, HALT three cycles after entry → HALTED with no CE issued.
- Mid-run RST=0 for one edge → all outputs back to reset values at that edge. CNT_CLR coincident with a CE → CE_CNT=0 and the pulse is still issued.
